spi_apb_sequencer: RTL and testbench
====================================

Name: spi_apb_sequencer

Overview:
APB master that sequences one CoreSPI instance (the spi_rf register set) through complete byte transfers so that a hardware client needs no CPU involvement. Accepts a request (slave select, byte count), then streams TX bytes in and RX bytes out. Programs control, slave-select and FIFO-clear registers, polls status and handles timeout and overflow. Sits between a hardware client (e.g. a flash/sensor reader) and the SPI core's APB slave port.

Parameters:
LEN_W, 8, width of byte count; max request length 2^LEN_W-1 bytes
TO_W, 12, poll-timeout counter width; timeout after 2^TO_W-1 consecutive non-ready status reads
CTRL1_VAL, 8'h03, value written to CTRL1 at start (enable, master)

Ports:
pclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
req_valid  in  1  request strobe
req_ready  out  1  high in IDLE only
req_ssel  in  8  slave-select mask for request
req_len  in  LEN_W  number of bytes to transfer
tx_valid  in  1  TX byte available
tx_ready  out  1  one-cycle pulse, tx_data consumed
tx_data  in  8  TX byte
rx_valid  out  1  one-cycle pulse, rx_data valid
rx_data  out  8  received byte, held until next rx_valid
done  out  1  one-cycle pulse at end of request
error  out  1  sticky, cleared on next request accept; timeout or RX overflow
busy  out  1  high whenever not IDLE
paddr  out  7  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB write
pwdata  out  8  APB write data
prdata  in  8  APB read data, valid when psel&penable

Behaviour:
- Reset: req_ready=1, busy=0, tx_ready=0, rx_valid=0, rx_data=0, done=0, error=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; state IDLE.
- CoreSPI map: CTRL1 0x00, RXDATA 0x08, TXDATA 0x0C, CMD 0x1C (bit0 clr_rx, bit1 clr_tx), STATUS 0x20 (bit2 rx_fifo_empty, bit4 rx_overflow), SSEL 0x24.
- APB access: setup cycle (psel=1, penable=0), then access cycle (psel=1, penable=1). No wait states, no pready. Next access may start in the cycle after access; otherwise psel=0. Read data is captured on the access cycle.
- States, in order:
  - IDLE: on req_valid&req_ready latch ssel and len; clear error.
  - CLR: write CMD=0x03.
  - SSEL: write SSEL=latched ssel.
  - EN: write CTRL1=CTRL1_VAL.
  - Byte loop:
    - TXW: wait tx_valid, then pulse tx_ready, latch data.
    - TX: write TXDATA.
    - POLL: read STATUS.
      - bit4=1 -> set error, go DESEL.
      - bit2=1 -> timeout cnt+1 and repeat POLL; at max -> set error, go DESEL.
      - bit2=0 -> go RX.
    - RX: read RXDATA; rx_data<=prdata and rx_valid pulse in the cycle after the access cycle; decrement count; count==0 -> DESEL, else TXW.
  - DESEL: write SSEL=0x00.
  - DIS: write CTRL1=0x00.
  - DONE: pulse done one cycle, then IDLE.
- First APB setup occurs in the cycle after request accept. Fixed-path latency with len=1, zero TX stall and one POLL: 16 cycles from accept to done.
- req_len=0: CLR, SSEL, EN, DESEL, DIS only; no TX/RX accesses; done pulses normally.
- Timeout counter resets at entry to each POLL sequence. An error does not abort DESEL/DIS, so the SPI core is always left disabled and deselected.
- req_valid while busy is ignored (req_ready=0).
- Reset mid-request: outputs return to reset values immediately, and the APB cycle in progress is abandoned.
- Byte count uses exact LEN_W arithmetic; no wrap.

Decomposition:
- Package spi_seq_pkg: register address constants, STATUS bit indices, CMD clear value, state enum.
- Sub-module spi_apb_xact: single-access APB engine. Inputs are start, write, addr and wdata; outputs are ack (on the access cycle) and rdata. It owns psel/penable/pwrite/paddr/pwdata.
- Top-level spi_apb_sequencer holds the FSM and counters.

Test Plan:
- Request ssel=0x01, len=1, tx_data=0xA5; slave model returns STATUS=0x00 then RXDATA=0x5A. Expect:
  - APB writes 0x1C=03, 0x24=01, 0x00=03, 0x0C=A5, read 0x20, read 0x08, write 0x24=00, write 0x00=00.
  - rx_data=0x5A with one rx_valid pulse, done 16 cycles after accept, error=0.
- len=3 with tx_valid held low 5 cycles before the second byte: exactly 3 tx_ready and 3 rx_valid pulses, in byte order; ssel stays asserted throughout.
- STATUS returns 0x04 four times then 0x00: expect 5 STATUS reads before the RXDATA read, no error.
- STATUS stuck at 0x04, TO_W=4: error=1 after 15 polls, then DESEL/DIS writes, done pulses; next request accept clears error.
- STATUS returns 0x10: error=1, no RXDATA read, DESEL then DIS issued; len=0 request: 5 writes only, then done.
- aresetn asserted during TX access: all outputs at reset values the same cycle; a subsequent request runs normally from CLR.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared definitions for the CoreSPI APB sequencer.
// Contents: the CoreSPI register map, the STATUS bit positions, the CMD value
// that clears both FIFOs, the FSM state encoding, and a small request record
// with constructors for the single-access APB engine.
package spi_seq_pkg;

    // CoreSPI register map (byte addresses on the 7-bit APB bus)
    localparam logic [6:0] ADDR_CTRL1  = 7'h00;
    localparam logic [6:0] ADDR_RXDATA = 7'h08;
    localparam logic [6:0] ADDR_TXDATA = 7'h0C;
    localparam logic [6:0] ADDR_CMD    = 7'h1C;
    localparam logic [6:0] ADDR_STATUS = 7'h20;
    localparam logic [6:0] ADDR_SSEL   = 7'h24;

    // STATUS bit positions
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_RX_OVF   = 4;

    // CMD value: clr_rx | clr_tx
    localparam logic [7:0] CMD_CLR_ALL = 8'h03;

    // FSM states, in sequence order
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_CLR   = 4'd1;
    localparam state_t ST_SSEL  = 4'd2;
    localparam state_t ST_EN    = 4'd3;
    localparam state_t ST_TXW   = 4'd4;
    localparam state_t ST_TX    = 4'd5;
    localparam state_t ST_POLL  = 4'd6;
    localparam state_t ST_RX    = 4'd7;
    localparam state_t ST_DESEL = 4'd8;
    localparam state_t ST_DIS   = 4'd9;
    localparam state_t ST_DONE  = 4'd10;

    // One APB access request towards spi_apb_xact
    typedef struct packed {
        logic       start;
        logic       write;
        logic [6:0] addr;
        logic [7:0] wdata;
    } xact_req_t;

    localparam xact_req_t XACT_NONE = '{start: 1'b0, write: 1'b0, addr: 7'h00, wdata: 8'h00};

    function automatic xact_req_t apb_wr(input logic [6:0] addr, input logic [7:0] data);
        xact_req_t r;
        r.start = 1'b1;
        r.write = 1'b1;
        r.addr  = addr;
        r.wdata = data;
        return r;
    endfunction

    function automatic xact_req_t apb_rd(input logic [6:0] addr);
        xact_req_t r;
        r.start = 1'b1;
        r.write = 1'b0;
        r.addr  = addr;
        r.wdata = 8'h00;
        return r;
    endfunction

endpackage

// File: rtl/spi_apb_xact.sv
// Single-access APB master engine (no wait states, no pready).
// A start pulse latches write/addr/wdata and drives the setup cycle on the
// next clock; the access cycle follows, during which ack is high and rdata
// carries prdata. A new start may be issued during the access cycle so that
// accesses run back to back.
// Ports: pclk/aresetn; start, write, addr, wdata (request); ack, rdata
// (completion); psel, penable, pwrite, paddr, pwdata, prdata (APB bus).
module spi_apb_xact
    import spi_seq_pkg::*;
(
    input  logic       pclk,
    input  logic       aresetn,
    input  logic       start,
    input  logic       write,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [6:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata
);

    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       pwrite_q, pwrite_d;
    logic [6:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;

    // Next bus phase: setup on start, then access, then idle
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (start) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = write;
            paddr_d   = addr;
            pwdata_d  = wdata;
        end else if (psel_q && !penable_q) begin
            penable_d = 1'b1;
        end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end
    end

    // Bus registers; reset abandons any access in flight
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 7'h00;
            pwdata_q  <= 8'h00;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign ack     = psel_q & penable_q;
    assign rdata   = prdata;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule

// File: rtl/spi_apb_sequencer.sv
// Sequences one CoreSPI instance through complete byte transfers over APB.
// A request (slave-select mask, byte count) clears the FIFOs, selects the
// slave and enables the core; each byte is then written to TXDATA, STATUS is
// polled until RX data is present, and RXDATA is read back. The core is always
// deselected and disabled at the end, even after a timeout or RX overflow.
// Ports: pclk/aresetn; req_* (request handshake); tx_* (TX byte stream);
// rx_valid/rx_data (RX byte stream); done/error/busy (status);
// paddr/psel/penable/pwrite/pwdata/prdata (APB master to CoreSPI).
module spi_apb_sequencer
    import spi_seq_pkg::*;
#(
    parameter int         LEN_W     = 8,
    parameter int         TO_W      = 12,
    parameter logic [7:0] CTRL1_VAL = 8'h03
) (
    input  logic             pclk,
    input  logic             aresetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_ssel,
    input  logic [LEN_W-1:0] req_len,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             done,
    output logic             error,
    output logic             busy,
    output logic [6:0]       paddr,
    output logic             psel,
    output logic             penable,
    output logic             pwrite,
    output logic [7:0]       pwdata,
    input  logic [7:0]       prdata
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]  TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    // The read that would make the count all-ones is the last one allowed
    localparam logic [TO_W-1:0]  TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t           state_q, state_d;
    logic [7:0]       ssel_q, ssel_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             error_q, error_d;
    logic             tx_ready_q, tx_ready_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             req_ready_q, req_ready_d;

    xact_req_t        xreq_s;
    logic             ack_s;
    logic [7:0]       rdata_s;
    logic             go_byte_s;
    logic             go_desel_s;

    // FSM next state, APB request selection and counter updates
    always_comb begin
        state_d    = state_q;
        ssel_d     = ssel_q;
        len_d      = len_q;
        to_cnt_d   = to_cnt_q;
        error_d    = error_q;
        tx_ready_d = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;
        xreq_s     = XACT_NONE;
        go_byte_s  = 1'b0;
        go_desel_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ssel_d  = req_ssel;
                    len_d   = req_len;
                    error_d = 1'b0;
                    xreq_s  = apb_wr(ADDR_CMD, CMD_CLR_ALL);
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR: begin
                if (ack_s) begin
                    xreq_s  = apb_wr(ADDR_SSEL, ssel_q);
                    state_d = ST_SSEL;
                end else begin
                    state_d = ST_CLR;
                end
            end
            ST_SSEL: begin
                if (ack_s) begin
                    xreq_s  = apb_wr(ADDR_CTRL1, CTRL1_VAL);
                    state_d = ST_EN;
                end else begin
                    state_d = ST_SSEL;
                end
            end
            ST_EN: begin
                if (ack_s) begin
                    go_desel_s = (len_q == '0);
                    go_byte_s  = (len_q != '0);
                end else begin
                    state_d = ST_EN;
                end
            end
            ST_TXW: begin
                go_byte_s = 1'b1;
            end
            ST_TX: begin
                if (ack_s) begin
                    to_cnt_d = '0;
                    xreq_s   = apb_rd(ADDR_STATUS);
                    state_d  = ST_POLL;
                end else begin
                    state_d = ST_TX;
                end
            end
            ST_POLL: begin
                if (!ack_s) begin
                    state_d = ST_POLL;
                end else if (rdata_s[STAT_RX_OVF]) begin
                    error_d    = 1'b1;
                    go_desel_s = 1'b1;
                end else if (rdata_s[STAT_RX_EMPTY]) begin
                    if (to_cnt_q == TO_LAST) begin
                        error_d    = 1'b1;
                        go_desel_s = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_ONE;
                        xreq_s   = apb_rd(ADDR_STATUS);
                    end
                end else begin
                    xreq_s  = apb_rd(ADDR_RXDATA);
                    state_d = ST_RX;
                end
            end
            ST_RX: begin
                if (ack_s) begin
                    rx_data_d  = rdata_s;
                    rx_valid_d = 1'b1;
                    len_d      = len_q - LEN_ONE;
                    go_desel_s = (len_q == LEN_ONE);
                    go_byte_s  = (len_q != LEN_ONE);
                end else begin
                    state_d = ST_RX;
                end
            end
            ST_DESEL: begin
                if (ack_s) begin
                    xreq_s  = apb_wr(ADDR_CTRL1, 8'h00);
                    state_d = ST_DIS;
                end else begin
                    state_d = ST_DESEL;
                end
            end
            ST_DIS: begin
                if (ack_s) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DIS;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte starts straight away when the client already has data ready,
        // so a zero-stall stream keeps the APB bus back to back
        if (go_byte_s) begin
            if (tx_valid) begin
                tx_ready_d = 1'b1;
                xreq_s     = apb_wr(ADDR_TXDATA, tx_data);
                state_d    = ST_TX;
            end else begin
                state_d = ST_TXW;
            end
        end else if (go_desel_s) begin
            xreq_s  = apb_wr(ADDR_SSEL, 8'h00);
            state_d = ST_DESEL;
        end else begin
            xreq_s = xreq_s;
        end

        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
    end

    // FSM, counters and registered client-side outputs
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            ssel_q      <= 8'h00;
            len_q       <= '0;
            to_cnt_q    <= '0;
            error_q     <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ssel_q      <= ssel_d;
            len_q       <= len_d;
            to_cnt_q    <= to_cnt_d;
            error_q     <= error_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    spi_apb_xact u_xact (
        .pclk    (pclk),
        .aresetn (aresetn),
        .start   (xreq_s.start),
        .write   (xreq_s.write),
        .addr    (xreq_s.addr),
        .wdata   (xreq_s.wdata),
        .ack     (ack_s),
        .rdata   (rdata_s),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata)
    );

    assign req_ready = req_ready_q;
    assign tx_ready  = tx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign done      = done_q;
    assign error     = error_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Self-checking bench for spi_apb_sequencer (TO_W=4, so a timeout is 15 polls).
// Each scenario task fills a scoreboard of expected APB accesses, RX bytes and
// slave responses, then runs the request cycle by cycle; APB accesses and RX
// bytes are popped and compared as the DUT produces them.
module tb_spi_apb_sequencer;

    localparam int LEN_W = 8;
    localparam int TO_W  = 4;

    logic             pclk;
    logic             aresetn;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_ssel;
    logic [LEN_W-1:0] req_len;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             done;
    logic             error;
    logic             busy;
    logic [6:0]       paddr;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [7:0]       pwdata;
    logic [7:0]       prdata;

    int n_cmp;
    int n_mis;

    logic [16:0] exp_apb[$];   // {write, addr, wdata (0 for reads)}
    logic [7:0]  rx_exp[$];
    logic [7:0]  status_q[$];  // slave STATUS responses, default when empty
    logic [7:0]  status_dflt;
    logic [7:0]  rxd_q[$];     // slave RXDATA responses
    logic [7:0]  tx_bytes[$];
    int          tx_gaps[$];   // cycles to keep tx_valid low before each byte
    int          tx_gap;

    spi_apb_sequencer #(.LEN_W(LEN_W), .TO_W(TO_W), .CTRL1_VAL(8'h03)) dut (
        .pclk      (pclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ssel  (req_ssel),
        .req_len   (req_len),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .done      (done),
        .error     (error),
        .busy      (busy),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
        exp_apb.push_back({1'b1, a, d});
    endtask

    task automatic exp_rd(input logic [6:0] a);
        exp_apb.push_back({1'b0, a, 8'h00});
    endtask

    task automatic exp_open(input logic [7:0] s);
        exp_wr(7'h1C, 8'h03);
        exp_wr(7'h24, s);
        exp_wr(7'h00, 8'h03);
    endtask

    task automatic exp_close();
        exp_wr(7'h24, 8'h00);
        exp_wr(7'h00, 8'h00);
    endtask

    // One normal byte: TX write, 'polls' STATUS reads (last one ready), RX read
    task automatic exp_byte(input logic [7:0] tx, input int gap, input int polls, input logic [7:0] rx);
        exp_wr(7'h0C, tx);
        for (int i = 0; i < polls; i++) begin
            exp_rd(7'h20);
            status_q.push_back((i == polls - 1) ? 8'h00 : 8'h04);
        end
        exp_rd(7'h08);
        rxd_q.push_back(rx);
        rx_exp.push_back(rx);
        tx_bytes.push_back(tx);
        tx_gaps.push_back(gap);
    endtask

    // Issue one request and service it until done; lat = clock edges from accept to done
    task automatic run_req(input logic [7:0] ssel, input logic [LEN_W-1:0] len, input int hold,
                           output int lat, output int rx_n, output int tx_n);
        int          cyc;
        bit          seen_done;
        logic [16:0] e;
        logic [16:0] o;
        logic [7:0]  e8;
        lat = -1; rx_n = 0; tx_n = 0; cyc = 0; seen_done = 1'b0;
        for (int w = 0; w < 10 && req_ready !== 1'b1; w++) @(negedge pclk);
        tx_gap = (tx_gaps.size() > 0) ? tx_gaps[0] : 0;
        if (tx_bytes.size() > 0 && tx_gap == 0) begin
            tx_valid = 1'b1;
            tx_data  = tx_bytes[0];
        end
        req_ssel  = ssel;
        req_len   = len;
        req_valid = 1'b1;
        while (!seen_done && cyc < 400) begin
            @(negedge pclk);
            cyc++;
            if (cyc >= hold) req_valid = 1'b0;
            if (cyc == 1) begin
                n_cmp++;
                if (busy !== 1'b1 || req_ready !== 1'b0 || error !== 1'b0) begin
                    n_mis++;
                    $display("FAIL accept_state: busy=%b req_ready=%b error=%b, required 1 0 0", busy, req_ready, error);
                end
            end
            if (psel === 1'b1 && penable === 1'b1) begin
                o = {pwrite, paddr, (pwrite === 1'b1) ? pwdata : 8'h00};
                n_cmp++;
                if (exp_apb.size() == 0) begin
                    n_mis++;
                    $display("FAIL apb_extra: got access %h, required none", o);
                end else begin
                    e = exp_apb.pop_front();
                    if (o !== e) begin
                        n_mis++;
                        $display("FAIL apb_access: got {w,addr,data}=%h, required %h", o, e);
                    end
                end
                if (pwrite === 1'b0 && paddr == 7'h20 && status_q.size() > 0) void'(status_q.pop_front());
                if (pwrite === 1'b0 && paddr == 7'h08 && rxd_q.size() > 0) void'(rxd_q.pop_front());
            end else if (psel === 1'b1) begin
                if (paddr == 7'h20) prdata = (status_q.size() > 0) ? status_q[0] : status_dflt;
                else if (paddr == 7'h08) prdata = (rxd_q.size() > 0) ? rxd_q[0] : 8'hEE;
                else prdata = 8'h00;
            end
            if (rx_valid === 1'b1) begin
                rx_n++;
                n_cmp++;
                if (rx_exp.size() == 0) begin
                    n_mis++;
                    $display("FAIL rx_extra: got rx_data=%h, required no rx_valid", rx_data);
                end else begin
                    e8 = rx_exp.pop_front();
                    if (rx_data !== e8) begin
                        n_mis++;
                        $display("FAIL rx_data: got %h, required %h", rx_data, e8);
                    end
                end
            end
            if (tx_ready === 1'b1) begin
                tx_n++;
                if (tx_bytes.size() > 0) begin
                    void'(tx_bytes.pop_front());
                    void'(tx_gaps.pop_front());
                end
                tx_valid = 1'b0;
                tx_gap = (tx_gaps.size() > 0) ? tx_gaps[0] : 0;
            end
            if (tx_valid === 1'b0 && tx_bytes.size() > 0) begin
                if (tx_gap == 0) begin
                    tx_valid = 1'b1;
                    tx_data  = tx_bytes[0];
                end else begin
                    tx_gap--;
                end
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                lat = cyc - 1;
            end
        end
        if (!seen_done) begin
            n_cmp++;
            n_mis++;
            $display("FAIL done_timeout: no done within %0d cycles, required done", cyc);
        end
        n_cmp++;
        if (exp_apb.size() != 0) begin
            n_mis++;
            $display("FAIL apb_missing: %0d accesses outstanding, required 0", exp_apb.size());
        end
        tx_valid  = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge pclk);
        n_cmp++;
        if ({req_ready, busy, tx_ready, rx_valid, rx_data, done, error, psel, penable, pwrite, paddr, pwdata}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00}) begin
            n_mis++;
            $display("FAIL reset_values: rdy=%b busy=%b txr=%b rxv=%b rxd=%h done=%b err=%b psel=%b pen=%b pw=%b pa=%h pd=%h",
                     req_ready, busy, tx_ready, rx_valid, rx_data, done, error, psel, penable, pwrite, paddr, pwdata);
        end
        aresetn = 1'b1;
        @(negedge pclk);
    endtask

    task automatic test_single();
        int lat, rxn, txn;
        exp_open(8'h01);
        exp_byte(8'hA5, 0, 1, 8'h5A);
        exp_close();
        run_req(8'h01, 8'd1, 1, lat, rxn, txn);
        n_cmp++;
        if (lat !== 16) begin n_mis++; $display("FAIL single_latency: got %0d, required 16", lat); end
        n_cmp++;
        if (rxn !== 1 || txn !== 1) begin n_mis++; $display("FAIL single_pulses: rx %0d tx %0d, required 1 1", rxn, txn); end
        n_cmp++;
        if (error !== 1'b0 || rx_data !== 8'h5A) begin n_mis++; $display("FAIL single_final: error=%b rx_data=%h, required 0 5a", error, rx_data); end
    endtask

    // Second byte arrives 10 cycles after the first is taken: the DUT waits in TXW about 5 cycles
    task automatic test_back_to_back();
        int lat, rxn, txn;
        exp_open(8'h40);
        exp_byte(8'h11, 0, 1, 8'h81);
        exp_byte(8'h22, 10, 1, 8'h82);
        exp_byte(8'h33, 0, 1, 8'h83);
        exp_close();
        run_req(8'h40, 8'd3, 3, lat, rxn, txn);
        n_cmp++;
        if (txn !== 3 || rxn !== 3) begin n_mis++; $display("FAIL len3_pulses: tx %0d rx %0d, required 3 3", txn, rxn); end
        n_cmp++;
        if (error !== 1'b0) begin n_mis++; $display("FAIL len3_error: got %b, required 0", error); end
    endtask

    task automatic test_poll_retry();
        int lat, rxn, txn;
        exp_open(8'h02);
        exp_byte(8'hC3, 0, 5, 8'h3C);
        exp_close();
        run_req(8'h02, 8'd1, 1, lat, rxn, txn);
        n_cmp++;
        if (error !== 1'b0 || rxn !== 1) begin n_mis++; $display("FAIL poll_retry: error=%b rx %0d, required 0 1", error, rxn); end
    endtask

    task automatic test_timeout();
        int lat, rxn, txn;
        status_dflt = 8'h04;
        exp_open(8'h08);
        exp_wr(7'h0C, 8'h77);
        for (int i = 0; i < 15; i++) exp_rd(7'h20);
        exp_close();
        tx_bytes.push_back(8'h77);
        tx_gaps.push_back(0);
        run_req(8'h08, 8'd1, 1, lat, rxn, txn);
        status_dflt = 8'h00;
        n_cmp++;
        if (error !== 1'b1 || rxn !== 0) begin n_mis++; $display("FAIL timeout: error=%b rx %0d, required 1 0", error, rxn); end
    endtask

    task automatic test_len0();
        int lat, rxn, txn;
        exp_open(8'h10);
        exp_close();
        run_req(8'h10, 8'd0, 1, lat, rxn, txn);
        n_cmp++;
        if (error !== 1'b0 || rxn !== 0 || txn !== 0) begin
            n_mis++;
            $display("FAIL len0: error=%b rx %0d tx %0d, required 0 0 0", error, rxn, txn);
        end
    endtask

    task automatic test_overflow();
        int lat, rxn, txn;
        exp_open(8'h20);
        exp_wr(7'h0C, 8'h3E);
        exp_rd(7'h20);
        status_q.push_back(8'h10);
        exp_close();
        tx_bytes.push_back(8'h3E);
        tx_gaps.push_back(0);
        run_req(8'h20, 8'd2, 1, lat, rxn, txn);
        n_cmp++;
        if (error !== 1'b1 || rxn !== 0) begin n_mis++; $display("FAIL overflow: error=%b rx %0d, required 1 0", error, rxn); end
    endtask

    task automatic test_reset_mid();
        int  lat, rxn, txn;
        bit  hit;
        hit = 1'b0;
        for (int w = 0; w < 10 && req_ready !== 1'b1; w++) @(negedge pclk);
        tx_valid  = 1'b1;
        tx_data   = 8'h99;
        req_ssel  = 8'h04;
        req_len   = 8'd1;
        req_valid = 1'b1;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge pclk);
            req_valid = 1'b0;
            if (psel === 1'b1 && penable === 1'b1 && paddr == 7'h0C) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin n_mis++; $display("FAIL reset_mid_reach: TX access not seen, required seen"); end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, busy, tx_ready, rx_valid, rx_data, done, error, psel, penable, pwrite, paddr, pwdata}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00}) begin
            n_mis++;
            $display("FAIL reset_mid_values: rdy=%b busy=%b rxd=%h err=%b psel=%b pen=%b pa=%h pd=%h",
                     req_ready, busy, rx_data, error, psel, penable, paddr, pwdata);
        end
        tx_valid = 1'b0;
        @(negedge pclk);
        aresetn = 1'b1;
        @(negedge pclk);
        exp_open(8'h04);
        exp_byte(8'h6B, 0, 2, 8'hB6);
        exp_close();
        run_req(8'h04, 8'd1, 1, lat, rxn, txn);
        n_cmp++;
        if (error !== 1'b0 || rxn !== 1 || rx_data !== 8'hB6) begin
            n_mis++;
            $display("FAIL reset_mid_rerun: error=%b rx %0d rx_data=%h, required 0 1 b6", error, rxn, rx_data);
        end
    endtask

    initial begin
        n_cmp = 0; n_mis = 0;
        aresetn = 1'b0; req_valid = 1'b0; req_ssel = 8'h00; req_len = '0;
        tx_valid = 1'b0; tx_data = 8'h00; prdata = 8'h00; status_dflt = 8'h00; tx_gap = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_poll_retry();
        test_timeout();
        test_len0();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
